// File: rtl/mutex_lock_sequencer.sv
// mutex_lock_sequencer: shares one mutex slave among NUM_REQ local requesters.
// Runs the try-lock sequence (write {owner,value}, read back, compare, back off,
// retry), arbitrates requesters round-robin and issues the release write.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no transaction; pick next requester after the RR pointer
// TRY_WR   | write {owner, LOCK_VALUE} to the mutex
// CHECK_RD | read mutex back; match -> HELD, otherwise back off
// BACKOFF  | wait RETRY_GAP cycles; abandon if the requester drops req
// HELD     | grant asserted to the selected requester
// REL_WR   | write {owner, 0} to release; RR pointer moves to this index
module mutex_lock_sequencer #(
    parameter int          NUM_REQ    = 2,
    parameter logic [15:0] OWNER_BASE = 16'h0001,
    parameter logic [15:0] LOCK_VALUE = 16'h0001,
    parameter int          RETRY_GAP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] rel_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               contended_o,
    output logic               m_address_o,
    output logic               m_chipselect_o,
    output logic               m_write_o,
    output logic               m_read_o,
    output logic [31:0]        m_writedata_o,
    input  logic [31:0]        m_readdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RETRY_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRY_WR,
        S_CHECK_RD,
        S_BACKOFF,
        S_HELD,
        S_REL_WR
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [15:0]        owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               lock_match;

    // Round-robin pick: first requester strictly after the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (!pick_found && req_i[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    assign lock_match = (m_readdata_i == {owner_q, LOCK_VALUE});

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    owner_d = OWNER_BASE + 16'(pick_idx);
                    state_d = S_TRY_WR;
                end
            end
            S_TRY_WR: state_d = S_CHECK_RD;
            S_CHECK_RD: begin
                if (lock_match) begin
                    state_d = S_HELD;
                end else begin
                    cnt_d   = CNT_W'(RETRY_GAP);
                    state_d = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                // Dropping req abandons the attempt; the pointer is left alone.
                if (!req_i[idx_q]) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Leave as the counter reaches zero: RETRY_GAP idle cycles.
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_TRY_WR;
                    end
                end
            end
            S_HELD: begin
                if (rel_i[idx_q] || !req_i[idx_q]) begin
                    state_d = S_REL_WR;
                end
            end
            S_REL_WR: begin
                ptr_d   = idx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore bus/grant outputs decoded from state; contended qualifies the readback.
    always_comb begin
        grant_o        = '0;
        busy_o         = (state_q != S_IDLE);
        contended_o    = 1'b0;
        m_address_o    = 1'b0;
        m_chipselect_o = 1'b0;
        m_write_o      = 1'b0;
        m_read_o       = 1'b0;
        m_writedata_o  = '0;
        case (state_q)
            S_TRY_WR: begin
                m_chipselect_o = 1'b1;
                m_write_o      = 1'b1;
                m_writedata_o  = {owner_q, LOCK_VALUE};
            end
            S_CHECK_RD: begin
                m_chipselect_o = 1'b1;
                m_read_o       = 1'b1;
                contended_o    = !lock_match;
            end
            S_HELD: begin
                grant_o[idx_q] = 1'b1;
            end
            S_REL_WR: begin
                m_chipselect_o = 1'b1;
                m_write_o      = 1'b1;
                m_writedata_o  = {owner_q, 16'h0000};
            end
            default: ;
        endcase
    end

endmodule
